// File: rtl/rr_sel_scheduler_if.sv
// Requester-side bundle for rr_sel_scheduler: request/data lines in,
// grant/select/registered mux result out.
interface rr_sel_scheduler_if #(
  parameter int NREQ = 4,
  parameter int SELW = 2
);
  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] IN;
  logic [NREQ-1:0] GNT;
  logic [SELW-1:0] SEL;
  logic            OUT;
  logic            VALID;
  logic            BUSY;

  modport master (output REQ, IN, input GNT, SEL, OUT, VALID, BUSY);
  modport slave  (input REQ, IN, output GNT, SEL, OUT, VALID, BUSY);
endinterface

// File: rtl/rr_sel_scheduler.sv
// Round-robin, quantum-limited owner of a shared 1-bit select mux.
// Optional urgent-requester-0 preemption: define RR_SEL_SCHED_PREEMPT_EN.
module rr_sel_scheduler #(
  parameter int NREQ    = 4,
  parameter int SELW    = 2,
  parameter int QUANTUM = 4
) (
  input logic               CLK,
  input logic               RST_N,
  rr_sel_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            valid_q, valid_d;
`ifdef RR_SEL_SCHED_PREEMPT_EN
  logic            pre_q, pre_d;
  logic            preempt;
`endif

  logic            req_sel, in_sel, hit_hi, last_cyc;
  logic [SELW-1:0] win_hi, win_lo, win;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    req_sel  = 1'b0;
    in_sel   = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    hit_hi   = 1'b0;
    last_cyc = 1'b0;
`ifdef RR_SEL_SCHED_PREEMPT_EN
    pre_d    = pre_q;
    preempt  = 1'b0;
`endif

    // Mux lookup; an out-of-range select matches nothing and reads 0.
    for (int j = 0; j < NREQ; j++) begin
      if (sel_q == SELW'(j)) begin
        req_sel = bus.REQ[j];
        in_sel  = bus.IN[j];
      end
    end

    // Lowest set index above LAST wins; otherwise wrap to the lowest set index.
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.REQ[j]) begin
        win_lo = SELW'(j);
        if (SELW'(j) > last_q) begin
          win_hi = SELW'(j);
          hit_hi = 1'b1;
        end
      end
    end
    win = hit_hi ? win_hi : win_lo;
`ifdef RR_SEL_SCHED_PREEMPT_EN
    if (pre_q && bus.REQ[0]) win = '0;
`endif

    case (state_q)
      S_IDLE, S_GAP: begin
`ifdef RR_SEL_SCHED_PREEMPT_EN
        pre_d = 1'b0;
`endif
        if (|bus.REQ) begin
          state_d = S_GRANT;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
          sel_d   = win;
          last_d  = win;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        last_cyc = !req_sel || (cnt_q == 8'(QUANTUM - 1));
`ifdef RR_SEL_SCHED_PREEMPT_EN
        preempt  = bus.REQ[0] && (sel_q != '0);
        last_cyc = last_cyc || preempt;
        pre_d    = preempt;
`endif
        if (last_cyc) begin
          state_d = S_GAP;
          gnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    out_d   = (state_q == S_GRANT) && in_sel;
    valid_d = (state_q == S_GRANT);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SELW'(NREQ - 1);
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef RR_SEL_SCHED_PREEMPT_EN
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef RR_SEL_SCHED_PREEMPT_EN
      pre_q   <= pre_d;
`endif
    end
  end

  assign bus.GNT   = gnt_q;
  assign bus.SEL   = sel_q;
  assign bus.OUT   = out_q;
  assign bus.VALID = valid_q;
  assign bus.BUSY  = (state_q != S_IDLE);
endmodule

// File: tb/tb_rr_sel_scheduler.sv
// Vector-table bench for rr_sel_scheduler (NREQ=4, QUANTUM=4); OUT is checked
// through a scoreboard of expected mux bits.
module tb_rr_sel_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_sel_scheduler_if #(.NREQ(4), .SELW(2)) bus ();

  rr_sel_scheduler #(.NREQ(4), .SELW(2), .QUANTUM(4)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  logic sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(logic r, logic [3:0] req, logic [3:0] gnt,
                              logic [1:0] sel, logic busy);
    vec_t v;
    v.rst_n = r; v.req = req; v.gnt = gnt; v.sel = sel; v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t       v;
    logic [3:0] in_v;
    logic [3:0] prev_gnt;
    logic [1:0] prev_sel;
    logic       exp_valid;
    logic       exp_out;

    bus.REQ = '0;
    bus.IN  = '0;

    // Reset, then idle.
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    repeat (10) add(1, 4'b0000, 4'b0000, 2'd0, 0);

    // Single holder: 4 grant cycles, 1 gap, regrant, then release.
    repeat (4) add(1, 4'b0001, 4'b0001, 2'd0, 1);
    add(1, 4'b0001, 4'b0000, 2'd0, 1);
    add(1, 4'b0001, 4'b0001, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 0);

    // All requesting: rotation 0,1,2,3,0 with one-cycle gaps.
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    for (int r = 0; r < 5; r++) begin
      repeat (4) add(1, 4'b1111, 4'(1 << (r % 4)), 2'(r % 4), 1);
      add(1, 4'b1111, 4'b0000, 2'(r % 4), 1);
    end
    add(1, 4'b0000, 4'b0000, 2'd0, 0);

    // Requester 2 drops early; next winner wraps past 3 to 0.
    add(1, 4'b0100, 4'b0100, 2'd2, 1);
    add(1, 4'b0111, 4'b0100, 2'd2, 1);
    add(1, 4'b0111, 4'b0100, 2'd2, 1);
    add(1, 4'b0011, 4'b0000, 2'd2, 1);
    add(1, 4'b0011, 4'b0001, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 0);

    // Reset during requester 1's second grant cycle; requester 0 wins after.
    add(1, 4'b0010, 4'b0010, 2'd1, 1);
    add(1, 4'b0010, 4'b0010, 2'd1, 1);
    add(0, 4'b0010, 4'b0000, 2'd0, 0);
    add(1, 4'b0011, 4'b0001, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 0);

    // Requester 3 holds; requester 0 rises during its first grant cycle.
    add(1, 4'b1000, 4'b1000, 2'd3, 1);
`ifdef RR_SEL_SCHED_PREEMPT_EN
    add(1, 4'b1001, 4'b0000, 2'd3, 1);
`else
    repeat (3) add(1, 4'b1001, 4'b1000, 2'd3, 1);
    add(1, 4'b1001, 4'b0000, 2'd3, 1);
`endif
    add(1, 4'b1001, 4'b0001, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 2'd0, 0);

    prev_gnt = '0;
    prev_sel = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      v         = vecs[i];
      in_v      = 4'($urandom_range(0, 15));
      rst_n     = v.rst_n;
      bus.REQ   = v.req;
      bus.IN    = in_v;
      // Data is captured from the holder shown before this edge.
      exp_valid = v.rst_n && (prev_gnt != 4'b0000);
      if (exp_valid) sb.push_back(in_v[prev_sel]);
      if (!v.rst_n) sb.delete();

      @(posedge clk);
      #1;
      chk("gnt",   i, 32'(bus.GNT),   32'(v.gnt));
      chk("sel",   i, 32'(bus.SEL),   32'(v.sel));
      chk("busy",  i, 32'(bus.BUSY),  32'(v.busy));
      chk("valid", i, 32'(bus.VALID), 32'(exp_valid));
      if (bus.VALID) begin
        if (sb.size() == 0) begin
          chk("sb_empty", i, 32'(1), 32'(0));
        end else begin
          exp_out = sb.pop_front();
          chk("out", i, 32'(bus.OUT), 32'(exp_out));
        end
      end else begin
        chk("out_idle", i, 32'(bus.OUT), 32'(0));
      end
      prev_gnt = v.gnt;
      prev_sel = v.sel;
    end
    chk("sb_drained", vecs.size(), 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
